score_argmax: RTL and testbench
===============================

SCORE_ARGMAX -- requirements
Module: score_argmax

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, base width matching the CNN datapath.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of FC output units (legal range 2..256).
REQ-003 SHALL derive localparams SCORE_WIDTH = 4*BITWIDTH and IDX_WIDTH = clog2(NUM_CLASSES) (minimum 1).
REQ-004 SHALL have port clk, input, 1, the single clock, with one clock domain only.
REQ-005 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have port clken, input, 1, global clock enable; when low, all non-reset state holds.
REQ-007 SHALL have port scores_in, input, SCORE_WIDTH*NUM_CLASSES; signed score i sits at bits [i*SCORE_WIDTH +: SCORE_WIDTH].
REQ-008 SHALL have port scores_valid, input, 1; a level that may stay high for several cycles.
REQ-009 SHALL have port result_ready, input, 1, consumer acknowledge.
REQ-010 SHALL have port class_out, output, IDX_WIDTH, winning class index.
REQ-011 SHALL have port max_score_out, output, SCORE_WIDTH, signed winning score.
REQ-012 SHALL have port margin_out, output, SCORE_WIDTH+1, unsigned (best minus second-best).
REQ-013 SHALL have port result_valid, output, 1, result-held flag.
REQ-014 SHALL have port busy, output, 1; high whenever the state is not IDLE.
REQ-015 SHALL have port dropped, output, 1, sticky flag set when a score frame is ignored.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, HOLD; all transitions occur only on clk edges with clken=1.
REQ-017 SHALL sample scores_valid into a prev register when clken=1; a capture event is scores_valid=1 while prev=0.
REQ-018 In IDLE, a capture event SHALL latch all of scores_in, and set best=score[0], best_idx=0, second=most-negative, idx=1, then move to SCAN.
REQ-019 In SCAN, each clken cycle SHALL compare latched score[idx] using signed comparison:
- if score > best: second=best, best=score, best_idx=idx
- else if score > second: second=score
- then idx increments.
REQ-020 Ties SHALL resolve to the lowest index (strict greater-than only); a tie with best SHALL update second.
REQ-021 After comparing idx=NUM_CLASSES-1, the block SHALL load class_out, max_score_out and margin_out (best-second, computed at SCORE_WIDTH+1 bits, never overflowing), set result_valid=1, and move to HOLD.
REQ-022 Latency SHALL be exactly NUM_CLASSES-1 clken cycles from the capture edge to result_valid high; clken-low cycles stretch it.
REQ-023 In HOLD, an edge with clken=1 and result_ready=1 SHALL clear result_valid and return to IDLE; the data outputs retain their values until the next result.
REQ-024 A capture event while in SCAN or HOLD SHALL be ignored and SHALL set dropped; dropped clears only on reset.
REQ-025 A capture event on the same edge as the HOLD handshake SHALL also be dropped, because capture is accepted only in IDLE.
REQ-026 Scores_in changes after capture SHALL NOT affect a scan in progress.

Reset
REQ-027 rst_n low SHALL immediately force the following, regardless of clken, including mid-SCAN (the partial scan is discarded):
- state = IDLE; prev = 0
- class_out, max_score_out, margin_out = 0
- result_valid, busy, dropped = 0
REQ-028 scores_valid high at reset release SHALL count as a capture event on the first clken edge.

Structure
REQ-029 SCORE_WIDTH and IDX_WIDTH derivations and the FSM state encodings SHALL live in the shared CNN parameter include used by the SimpleCNN stages.
REQ-030 SHALL be a single module with no sub-modules; the compare step is inline combinational logic feeding the registers.

Verification
REQ-031 Scores 0..9 = {5,-3,12,7,12,0,-8,1,2,3}, scores_valid held 4 cycles, result_ready=1 -> class_out=2, max=12, margin=0, result_valid after 9 cycles for one cycle, dropped=0.
REQ-032 All ten scores equal to -2147483648 -> class_out=0, max=0x80000000, margin=0.
REQ-033 Scores {2147483647, -2147483648, rest -2147483648} -> class_out=0, margin=0x0FFFFFFFF (33-bit).
REQ-034 Second valid rising edge 3 cycles after the first -> first result unaffected, dropped=1; result_ready low for 5 cycles -> result_valid and outputs hold stable.
REQ-035 clken toggled 50% during SCAN -> latency stretches to 9 enabled cycles with the same result; rst_n pulsed mid-SCAN -> all outputs 0, busy=0, and the next frame is processed correctly.

Source files
------------

// File: rtl/score_argmax_pkg.sv
`default_nettype none
// ============================================================================
// score_argmax_pkg : shared CNN-stage widths and argmax FSM state encodings
// Revision 1.0
// ============================================================================
package score_argmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Scores are accumulated at four times the datapath base width.
    function automatic int calc_score_width(input int bitwidth);
        return 4 * bitwidth;
    endfunction

    function automatic int calc_idx_width(input int num_classes);
        return (num_classes <= 2) ? 1 : $clog2(num_classes);
    endfunction

endpackage : score_argmax_pkg
`default_nettype wire

// File: rtl/score_argmax.sv
`default_nettype none
// ============================================================================
// score_argmax : sequential argmax over FC scores, one class per enabled cycle,
//                reporting winning index, its score and the best/second margin
// Revision 1.0
// ============================================================================
module score_argmax
    import score_argmax_pkg::*;
#(
    parameter int  BITWIDTH    = 8,
    parameter int  NUM_CLASSES = 10,
    localparam int SCORE_WIDTH = calc_score_width(BITWIDTH),
    localparam int IDX_WIDTH   = calc_idx_width(NUM_CLASSES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clken,
    input  logic [SCORE_WIDTH*NUM_CLASSES-1:0] scores_in,
    input  logic                               scores_valid,
    input  logic                               result_ready,
    output logic [IDX_WIDTH-1:0]               class_out,
    output logic [SCORE_WIDTH-1:0]             max_score_out,
    output logic [SCORE_WIDTH:0]               margin_out,
    output logic                               result_valid,
    output logic                               busy,
    output logic                               dropped
);

    localparam logic [SCORE_WIDTH-1:0] c_most_neg = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]   c_last_idx = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t r_state;
    state_t w_state_next;

    logic                          r_prev;
    logic [SCORE_WIDTH-1:0]        r_scores [NUM_CLASSES];
    logic [SCORE_WIDTH-1:0]        w_scores_in [NUM_CLASSES];
    logic signed [SCORE_WIDTH-1:0] r_best;
    logic signed [SCORE_WIDTH-1:0] r_second;
    logic [IDX_WIDTH-1:0]          r_best_idx;
    logic [IDX_WIDTH-1:0]          r_idx;

    logic                          w_capture;
    logic                          w_load;
    logic                          w_step;
    logic                          w_finish;
    logic                          w_ack;
    logic                          w_drop;
    logic signed [SCORE_WIDTH-1:0] w_cur;
    logic signed [SCORE_WIDTH-1:0] w_best_n;
    logic signed [SCORE_WIDTH-1:0] w_second_n;
    logic [IDX_WIDTH-1:0]          w_best_idx_n;
    logic [SCORE_WIDTH:0]          w_margin;

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
        assign w_scores_in[gi] = scores_in[gi*SCORE_WIDTH +: SCORE_WIDTH];
    end

    assign w_capture = scores_valid & ~r_prev;
    assign w_drop    = clken & w_capture & (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_ack        = 1'b0;
        if (clken) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        w_load       = 1'b1;
                        w_state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    w_step = 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        w_ack        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Strict greater-than keeps the lowest index on ties; an equal score still
    // raises second so the margin of a tie is zero.
    always_comb begin
        w_cur        = r_scores[r_idx];
        w_best_n     = r_best;
        w_second_n   = r_second;
        w_best_idx_n = r_best_idx;
        if (w_cur > r_best) begin
            w_second_n   = r_best;
            w_best_n     = w_cur;
            w_best_idx_n = r_idx;
        end else if (w_cur > r_second) begin
            w_second_n = w_cur;
        end
        w_margin = {w_best_n[SCORE_WIDTH-1], w_best_n} - {w_second_n[SCORE_WIDTH-1], w_second_n};
    end

    always_ff @(posedge clk) begin
        if (clken && w_load) begin
            r_scores <= w_scores_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev        <= 1'b0;
            r_best        <= '0;
            r_second      <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            class_out     <= '0;
            max_score_out <= '0;
            margin_out    <= '0;
            result_valid  <= 1'b0;
            dropped       <= 1'b0;
        end else if (clken) begin
            r_prev <= scores_valid;
            if (w_load) begin
                r_best     <= w_scores_in[0];
                r_second   <= c_most_neg;
                r_best_idx <= '0;
                r_idx      <= IDX_WIDTH'(1);
            end
            if (w_step) begin
                r_best     <= w_best_n;
                r_second   <= w_second_n;
                r_best_idx <= w_best_idx_n;
                r_idx      <= r_idx + 1'b1;
            end
            if (w_finish) begin
                class_out     <= w_best_idx_n;
                max_score_out <= w_best_n;
                margin_out    <= w_margin;
                result_valid  <= 1'b1;
            end
            if (w_ack) begin
                result_valid <= 1'b0;
            end
            if (w_drop) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule : score_argmax
`default_nettype wire

// File: tb/tb_score_argmax.sv
`default_nettype none
// ============================================================================
// tb_score_argmax : directed scoreboard bench for score_argmax
// Revision 1.0
// ============================================================================
module tb_score_argmax;

    localparam int N  = 10;
    localparam int SW = 32;
    localparam int IW = 4;
    localparam int VW = SW * N;

    logic          clk;
    logic          rst_n;
    logic          clken;
    logic [VW-1:0] scores_in;
    logic          scores_valid;
    logic          result_ready;
    logic [IW-1:0] class_out;
    logic [SW-1:0] max_score_out;
    logic [SW:0]   margin_out;
    logic          result_valid;
    logic          busy;
    logic          dropped;

    score_argmax #(.BITWIDTH(8), .NUM_CLASSES(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clken         (clken),
        .scores_in     (scores_in),
        .scores_valid  (scores_valid),
        .result_ready  (result_ready),
        .class_out     (class_out),
        .max_score_out (max_score_out),
        .margin_out    (margin_out),
        .result_valid  (result_valid),
        .busy          (busy),
        .dropped       (dropped)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [SW-1:0] mx;
        logic [SW:0]   mg;
        int            start;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   errors   = 0;
    int   checks   = 0;
    int   results  = 0;
    int   en_edges = 0;
    logic rv_prev  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enabled-edge counter used to time the expected latency.
    always @(posedge clk) begin
        if (rst_n && clken) en_edges <= en_edges + 1;
    end

    // Winner is the first maximum; second-best is the largest of the others.
    function automatic exp_t model(input logic [VW-1:0] v, input int start);
        exp_t e;
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] b;
        logic signed [SW-1:0] sec;
        int bi;
        bi  = 0;
        b   = v[SW-1:0];
        for (int i = 1; i < N; i++) begin
            s = v[i*SW +: SW];
            if (s > b) begin
                b  = s;
                bi = i;
            end
        end
        sec = 32'sh8000_0000;
        for (int j = 0; j < N; j++) begin
            s = v[j*SW +: SW];
            if (j != bi && s > sec) sec = s;
        end
        e.idx   = IW'(bi);
        e.mx    = b;
        e.mg    = {b[SW-1], b} - {sec[SW-1], sec};
        e.start = start;
        return e;
    endfunction

    function automatic logic [VW-1:0] pack(input int vals [N]);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*SW +: SW] = vals[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic on_result();
        exp_t e;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_result observed=valid expected=no_result");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("class_out", 64'(class_out), 64'(e.idx));
            chk("max_score_out", 64'(max_score_out), 64'(e.mx));
            chk("margin_out", 64'(margin_out), 64'(e.mg));
            chk("latency", 64'(en_edges - e.start), 64'(N));
            last_exp = e;
            results++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n && result_valid && !rv_prev) on_result();
        rv_prev = result_valid;
    endtask

    task automatic send(input logic [VW-1:0] v, input int hold, input bit push);
        scores_in    = v;
        scores_valid = 1'b1;
        if (push) q.push_back(model(v, en_edges));
        repeat (hold) tick();
        scores_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int maxc);
        int n0;
        int k;
        n0 = results;
        k  = 0;
        while (results == n0 && k < maxc) begin
            tick();
            k++;
        end
        chk(tag, 64'(results != n0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int            va [N];
        logic [VW-1:0] v;

        rst_n        = 1'b0;
        clken        = 1'b1;
        scores_in    = '0;
        scores_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();
        chk("rst_class", 64'(class_out), 64'd0);
        chk("rst_max", 64'(max_score_out), 64'd0);
        chk("rst_margin", 64'(margin_out), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        rst_n = 1'b1;
        tick();

        // Tie between index 2 and 4 on the maximum.
        va = '{5, -3, 12, 7, 12, 0, -8, 1, 2, 3};
        send(pack(va), 4, 1'b1);
        wait_result("A_timeout", 30);
        chk("A_class", 64'(class_out), 64'd2);
        chk("A_margin", 64'(margin_out), 64'd0);
        tick();
        chk("A_valid_one_cycle", 64'(result_valid), 64'd0);
        chk("A_busy", 64'(busy), 64'd0);
        chk("A_dropped", 64'(dropped), 64'd0);

        va = '{default: 32'h8000_0000};
        send(pack(va), 1, 1'b1);
        wait_result("B_timeout", 30);
        chk("B_max", 64'(max_score_out), 64'h8000_0000);
        tick();

        va = '{default: 32'h8000_0000};
        va[0] = 32'h7FFF_FFFF;
        send(pack(va), 1, 1'b1);
        wait_result("C_timeout", 30);
        tick();
        chk("C_margin", 64'(margin_out), 64'h0_FFFF_FFFF);
        chk("C_class", 64'(class_out), 64'd0);

        // Second rising edge 3 cycles after the first must be dropped.
        result_ready = 1'b0;
        va = '{-7, 4, 9, -100, 9, 3, 20, 19, 20, 0};
        send(pack(va), 1, 1'b1);
        tick();
        tick();
        va = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000};
        scores_in    = pack(va);
        scores_valid = 1'b1;
        tick();
        scores_valid = 1'b0;
        chk("D_dropped", 64'(dropped), 64'd1);
        wait_result("D_timeout", 30);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("D_hold_valid", 64'(result_valid), 64'd1);
            chk("D_hold_class", 64'(class_out), 64'(last_exp.idx));
            chk("D_hold_max", 64'(max_score_out), 64'(last_exp.mx));
        end
        result_ready = 1'b1;
        tick();
        chk("D_ack", 64'(result_valid), 64'd0);
        chk("D_retain_max", 64'(max_score_out), 64'(last_exp.mx));

        // Clock enable toggled every cycle through the scan.
        va = '{1, 2, 3, -4, 50, 6, 50, -8, 49, 10};
        send(pack(va), 1, 1'b1);
        begin
            int n0;
            n0 = results;
            for (int k = 0; k < 60 && results == n0; k++) begin
                clken = ~clken;
                tick();
            end
            chk("E_timeout", 64'(results != n0), 64'd1);
        end
        clken = 1'b1;
        tick();

        // Asynchronous reset in the middle of a scan.
        va = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        send(pack(va), 1, 1'b0);
        tick();
        tick();
        chk("F_busy_mid", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_class", 64'(class_out), 64'd0);
        chk("F_max", 64'(max_score_out), 64'd0);
        chk("F_margin", 64'(margin_out), 64'd0);
        chk("F_valid", 64'(result_valid), 64'd0);
        chk("F_busy", 64'(busy), 64'd0);
        chk("F_dropped", 64'(dropped), 64'd0);

        // Valid already high when reset releases counts as a capture.
        va = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -1};
        scores_in    = pack(va);
        scores_valid = 1'b1;
        result_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        q.push_back(model(scores_in, en_edges));
        tick();
        scores_valid = 1'b0;
        wait_result("G_timeout", 30);
        chk("G_dropped", 64'(dropped), 64'd0);

        // Capture on the handshake edge is dropped.
        va = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 4};
        scores_in    = pack(va);
        scores_valid = 1'b1;
        result_ready = 1'b1;
        tick();
        chk("H_valid", 64'(result_valid), 64'd0);
        chk("H_busy", 64'(busy), 64'd0);
        chk("H_dropped", 64'(dropped), 64'd1);
        tick();
        chk("H_no_capture", 64'(busy), 64'd0);
        scores_valid = 1'b0;
        tick();

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) va[i] = int'($urandom_range(0, 7)) - 4;
            v = pack(va);
            send(v, 2, 1'b1);
            wait_result("R_timeout", 30);
            tick();
        end

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_score_argmax
`default_nettype wire
